// File: rtl/numled_scan_ctrl.sv
// numled_scan_ctrl: multiplexed common-anode seven-segment scanner with a
// frame-synchronous double buffer, anti-ghost blanking, masking, DP and LZ suppression.
module numled_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [4*DIGITS-1:0] wr_data,
  input  logic [DIGITS-1:0]   wr_dp,
  input  logic [DIGITS-1:0]   wr_mask,
  input  logic                wr_lzb,
  output logic [DIGITS-1:0]   led_en,
  output logic [6:0]          led_seg,
  output logic                led_dp,
  output logic                frame_done,
  output logic                pending
);

  localparam int P_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [P_W-1:0]   P_LAST   = P_W'(CLK_DIV - 1);
  localparam logic [P_W-1:0]   P_BLANK  = P_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'b1111111;

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   mask;
    logic                lzb;
  } buf_t;

  localparam buf_t BUF_RST = '{data: '0, dp: '0, mask: '1, lzb: 1'b0};

  logic [P_W-1:0]    r_p;
  logic [IDX_W-1:0]  r_idx;
  buf_t              r_pend_buf;
  buf_t              r_disp_buf;
  logic              r_pending;
  logic              r_frame_done;
  logic [DIGITS-1:0] r_led_en;
  logic [6:0]        r_led_seg;
  logic              r_led_dp;

  buf_t              w_wr_buf;
  logic              w_p_wrap;
  logic              w_boundary;
  logic [DIGITS-1:0] w_lz_blank;
  logic [3:0]        w_nib;
  logic              w_vis;
  logic              w_dp_bit;
  logic [DIGITS-1:0] w_onehot;
  logic              w_active;
  logic [DIGITS-1:0] w_led_en_nxt;
  logic [6:0]        w_led_seg_nxt;
  logic              w_led_dp_nxt;

  assign w_wr_buf   = '{data: wr_data, dp: wr_dp, mask: wr_mask, lzb: wr_lzb};
  assign w_p_wrap   = (r_p == P_LAST);
  assign w_boundary = w_p_wrap && (r_idx == IDX_LAST);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // Slot timing: prescaler inside a slot, digit index across slots.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_idx <= '0;
    end else if (w_p_wrap) begin
      r_p   <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_p <= r_p + 1'b1;
    end
  end

  // A write on the boundary edge lands in the pending buffer after the commit
  // has taken the old pending contents, so it stays pending for one more frame.
  // NOTE: both buffers are reset because the power-up display contents are defined (all zeros, all shown).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_buf <= BUF_RST;
      r_disp_buf <= BUF_RST;
      r_pending  <= 1'b0;
    end else begin
      if (w_boundary && r_pending) r_disp_buf <= r_pend_buf;
      if (wr_en)                   r_pend_buf <= w_wr_buf;
      if (wr_en)                   r_pending  <= 1'b1;
      else if (w_boundary)         r_pending  <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    logic v_all_zero;
    w_lz_blank = '0;
    v_all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_all_zero    = v_all_zero && (r_disp_buf.data[4*i +: 4] == 4'h0);
      w_lz_blank[i] = r_disp_buf.lzb && (i != 0) && v_all_zero;
    end
  end

  always_comb begin
    w_nib    = 4'h0;
    w_vis    = 1'b0;
    w_dp_bit = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == r_idx) begin
        w_nib       = r_disp_buf.data[4*i +: 4];
        w_vis       = r_disp_buf.mask[i] && !w_lz_blank[i];
        w_dp_bit    = r_disp_buf.dp[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Anti-ghost window at the start of each slot keeps every digit dark.
  always_comb begin
    w_active      = w_vis && (r_p >= P_BLANK);
    w_led_en_nxt  = '1;
    w_led_seg_nxt = SEG_OFF;
    w_led_dp_nxt  = 1'b1;
    if (w_active) begin
      w_led_en_nxt  = ~w_onehot;
      w_led_seg_nxt = seg_decode(w_nib);
      w_led_dp_nxt  = ~w_dp_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_en     <= '1;
      r_led_seg    <= SEG_OFF;
      r_led_dp     <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_led_en     <= w_led_en_nxt;
      r_led_seg    <= w_led_seg_nxt;
      r_led_dp     <= w_led_dp_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign led_en     = r_led_en;
  assign led_seg    = r_led_seg;
  assign led_dp     = r_led_dp;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

// File: tb/tb_numled_scan_ctrl.sv
// Self-checking bench for numled_scan_ctrl: directed writes, expected outputs
// queued per cycle (counted from reset release) and compared when that cycle arrives.
module tb_numled_scan_ctrl;

  localparam int DIGITS       = 4;
  localparam int CLK_DIV      = 8;
  localparam int BLANK_CYCLES = 2;

  localparam logic [6:0] S0   = 7'b0000001;
  localparam logic [6:0] S1   = 7'b1001111;
  localparam logic [6:0] S2   = 7'b0010010;
  localparam logic [6:0] S3   = 7'b0000110;
  localparam logic [6:0] S4   = 7'b1001100;
  localparam logic [6:0] S5   = 7'b0100100;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SB   = 7'b1100000;
  localparam logic [6:0] SOFF = 7'b1111111;
  localparam logic [11:0] IDLE_OUT = {4'b1111, SOFF, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_mask;
  logic        wr_lzb;
  logic [3:0]  led_en;
  logic [6:0]  led_seg;
  logic        led_dp;
  logic        frame_done;
  logic        pending;

  numled_scan_ctrl #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .wr_mask(wr_mask), .wr_lzb(wr_lzb), .led_en(led_en), .led_seg(led_seg),
    .led_dp(led_dp), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef enum {SIG_OUT, SIG_FD, SIG_PEND} sig_e;
  typedef struct {
    string       tag;
    int          cyc;
    sig_e        sig;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  function automatic logic [11:0] observe(input sig_e s);
    case (s)
      SIG_OUT: return {led_en, led_seg, led_dp};
      SIG_FD:  return {11'd0, frame_done};
      default: return {11'd0, pending};
    endcase
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic void push_out(input string tag, input int c, input logic [3:0] en,
                                   input logic [6:0] seg, input logic d);
    exp_t e;
    e.tag = tag; e.cyc = c; e.sig = SIG_OUT; e.val = {en, seg, d};
    sb.push_back(e);
  endfunction

  function automatic void push_idle(input string tag, input int c);
    push_out(tag, c, 4'b1111, SOFF, 1'b1);
  endfunction

  function automatic void push_bit(input string tag, input int c, input sig_e s, input logic v);
    exp_t e;
    e.tag = tag; e.cyc = c; e.sig = s; e.val = {11'd0, v};
    sb.push_back(e);
  endfunction

  // Cycle k = state just after the k-th rising edge since reset release, sampled 1ns later.
  task automatic step_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  task automatic run_to(input int k);
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= k) begin
      e = sb.pop_front();
      step_to(e.cyc);
      check(e.tag, observe(e.sig), e.val);
    end
    step_to(k);
  endtask

  // Issue one write that the DUT samples at edge 'at'.
  task automatic write_buf(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] m,
                           input logic l, input int at);
    run_to(at - 1);
    wr_en = 1'b1; wr_data = d; wr_dp = dp; wr_mask = m; wr_lzb = l;
    run_to(at);
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_dp = '0; wr_mask = '0; wr_lzb = 1'b0;
    #23;
    check("rst_out",  observe(SIG_OUT),  IDLE_OUT);
    check("rst_fd",   observe(SIG_FD),   12'd0);
    check("rst_pend", observe(SIG_PEND), 12'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    cyc = 0;

    // Power-up frame: zeros on every digit, blanking window, frame pulse.
    push_idle("f0_e1_blank", 1);
    push_idle("f0_e2_blank", 2);
    push_out ("f0_s0_first", 3, 4'b1110, S0, 1'b1);
    push_bit ("f0_pend", 5, SIG_PEND, 1'b0);
    push_out ("f0_s0_last", 8, 4'b1110, S0, 1'b1);
    push_idle("f0_s1_blank_a", 9);
    push_idle("f0_s1_blank_b", 10);
    push_out ("f0_s1", 11, 4'b1101, S0, 1'b1);
    push_out ("f0_s2", 19, 4'b1011, S0, 1'b1);
    push_out ("f0_s3", 27, 4'b0111, S0, 1'b1);
    push_bit ("fd_31", 31, SIG_FD, 1'b0);
    push_bit ("fd_32", 32, SIG_FD, 1'b1);
    push_bit ("fd_33", 33, SIG_FD, 1'b0);

    // Mid-frame write holds off until the boundary.
    push_bit ("wr1_pend_pre", 40, SIG_PEND, 1'b0);
    push_bit ("wr1_pend_set", 41, SIG_PEND, 1'b1);
    push_out ("f1_s1_old", 43, 4'b1101, S0, 1'b1);
    push_out ("f1_s2_old", 51, 4'b1011, S0, 1'b1);
    push_out ("f1_s3_old", 59, 4'b0111, S0, 1'b1);
    push_bit ("wr1_pend_hold", 63, SIG_PEND, 1'b1);
    push_bit ("fd_64", 64, SIG_FD, 1'b1);
    push_bit ("wr1_pend_clr", 64, SIG_PEND, 1'b0);
    push_out ("f2_s0_4", 67, 4'b1110, S4, 1'b1);
    push_idle("f2_s1_blank", 73);
    push_out ("f2_s1_3", 75, 4'b1101, S3, 1'b1);
    push_out ("f2_s2_2", 83, 4'b1011, S2, 1'b1);
    push_out ("f2_s3_1", 91, 4'b0111, S1, 1'b1);
    write_buf(16'h1234, 4'b0000, 4'b1111, 1'b0, 41);

    // Write landing on the boundary edge waits one extra frame.
    push_bit ("bnd_pend_96", 96, SIG_PEND, 1'b1);
    push_bit ("fd_96", 96, SIG_FD, 1'b1);
    push_bit ("bnd_pend_97", 97, SIG_PEND, 1'b1);
    push_out ("f3_s0_A", 99, 4'b1110, SA, 1'b1);
    push_out ("f3_s1_A", 107, 4'b1101, SA, 1'b1);
    push_bit ("bnd_pend_127", 127, SIG_PEND, 1'b1);
    push_bit ("bnd_pend_128", 128, SIG_PEND, 1'b0);
    push_out ("f4_s0_b", 131, 4'b1110, SB, 1'b1);
    push_out ("f4_s3_b", 155, 4'b0111, SB, 1'b1);
    write_buf(16'hAAAA, 4'b0000, 4'b1111, 1'b0, 80);
    write_buf(16'hBBBB, 4'b0000, 4'b1111, 1'b0, 96);

    // Leading-zero suppression.
    push_out ("lz50_s0", 163, 4'b1110, S0, 1'b1);
    push_out ("lz50_s1", 171, 4'b1101, S5, 1'b1);
    push_idle("lz50_s2", 179);
    push_idle("lz50_s2_end", 184);
    push_idle("lz50_s3", 187);
    push_out ("lz00_s0", 195, 4'b1110, S0, 1'b1);
    push_idle("lz00_s1", 203);
    push_idle("lz00_s2", 211);
    push_idle("lz00_s3", 219);
    write_buf(16'h0050, 4'b0000, 4'b1111, 1'b1, 136);
    write_buf(16'h0000, 4'b0000, 4'b1111, 1'b1, 170);

    // Digit mask and decimal point.
    push_idle("mk_s0_blank", 226);
    push_out ("mk_s0_first", 227, 4'b1110, S8, 1'b0);
    push_out ("mk_s0_last", 232, 4'b1110, S8, 1'b0);
    push_idle("mk_s1_blank", 233);
    push_idle("mk_s1_hidden", 235);
    push_idle("mk_s1_hidden_end", 240);
    push_out ("mk_s2", 243, 4'b1011, S8, 1'b1);
    push_idle("mk_s3_hidden", 251);
    write_buf(16'h8888, 4'b0001, 4'b0101, 1'b0, 200);

    // Asynchronous reset mid-slot-2 with a write pending.
    push_bit ("ar_pend_set", 261, SIG_PEND, 1'b1);
    push_out ("ar_s2_live", 276, 4'b1011, S8, 1'b1);
    write_buf(16'h1234, 4'b1111, 4'b1111, 1'b0, 260);
    run_to(277);
    rst_n = 1'b0;
    #1;
    check("ar_out_idle", observe(SIG_OUT),  IDLE_OUT);
    check("ar_pend_clr", observe(SIG_PEND), 12'd0);
    check("ar_fd_clr",   observe(SIG_FD),   12'd0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    cyc = 0;

    push_out ("rr_s0", 3, 4'b1110, S0, 1'b1);
    push_bit ("rr_pend", 5, SIG_PEND, 1'b0);
    push_out ("rr_s1", 11, 4'b1101, S0, 1'b1);
    push_out ("rr_s2", 19, 4'b1011, S0, 1'b1);
    push_out ("rr_s3", 27, 4'b0111, S0, 1'b1);
    push_bit ("rr_fd", 32, SIG_FD, 1'b1);
    push_bit ("rr_pend_f1", 33, SIG_PEND, 1'b0);
    push_out ("rr_f1_s0", 35, 4'b1110, S0, 1'b1);
    run_to(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/numled_scan_ctrl.md
# numled_scan_ctrl

Parametrised multiplexed seven-segment scan controller for the board NUMLED bank. It scans DIGITS common-anode digits from a frame-synchronous display buffer. A write port loads a pending buffer, which commits only at frame boundaries, so a displayed frame never tears. The block adds a refresh prescaler, anti-ghost blanking, per-digit masking, decimal points and leading-zero suppression, and sits between the IO bus data register and the board pins.

## Interface
- DIGITS, 8, number of digits scanned (1..16)
- CLK_DIV, 100000, clk cycles per digit slot (>= 2)
- BLANK_CYCLES, 16, all-off cycles at the start of each slot (0 <= BLANK_CYCLES < CLK_DIV)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  load pending buffer from wr_* this cycle
- wr_data  in  4*DIGITS  hex nibbles; digit i = wr_data[4i+3:4i]
- wr_dp  in  DIGITS  decimal point per digit, 1 = lit
- wr_mask  in  DIGITS  digit enable, 1 = shown
- wr_lzb  in  1  leading-zero blanking enable
- led_en  out  DIGITS  digit enables, active-low
- led_seg  out  7  {ca,cb,cc,cd,ce,cf,cg}, active-low
- led_dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse at each frame boundary
- pending  out  1  pending buffer holds uncommitted data

## Operation
- Prescaler p counts 0..CLK_DIV-1. Digit index idx advances when p == CLK_DIV-1 and wraps from DIGITS-1 to 0.
- Frame = DIGITS*CLK_DIV cycles. The frame boundary is the edge where p == CLK_DIV-1 and idx == DIGITS-1.
- wr_en loads wr_data, wr_dp, wr_mask and wr_lzb into the pending buffer and sets pending. Multiple writes in one frame: the last write wins.
- At the frame boundary, if pending is set, the pending buffer copies to the display buffer and pending clears.
- wr_en in the boundary cycle: the commit uses the pending contents from before this write. The new write stays pending (pending = 1) until the next boundary.
- Digit i is visible when mask[i] = 1 and it is not LZ-blanked.
- LZ-blanked: lzb = 1, i != 0, and nibbles i..DIGITS-1 are all zero. Digit 0 is never LZ-blanked.
- Active-slot enable:
  - Visible digit: led_en = ~(1 << idx).
  - Invisible digit: led_en is all ones for the whole slot; the slot time is still consumed.
- Blanking window: while p < BLANK_CYCLES, led_en is all ones, led_seg = 7'b1111111 and led_dp = 1.
- Segment decode (active-low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- While led_en is all ones, led_seg = 7'b1111111 and led_dp = 1. Otherwise led_dp = ~dp[idx].

## Timing
- Reset (async) clears:
  - p = 0, idx = 0, pending = 0, frame_done = 0.
  - display and pending buffers: data 0, dp 0, mask all ones, lzb 0.
- Reset output values: led_en all ones, led_seg 7'b1111111, led_dp 1.
- Outputs are registered from the current (p, idx, display buffer), so they lag the counter state by one cycle.
- First enable after reset release: led_en = ~1 at edge BLANK_CYCLES+1. It holds for CLK_DIV-BLANK_CYCLES cycles, followed by BLANK_CYCLES all-off cycles, and the pattern repeats.
- frame_done is registered: it is high for the one cycle after the boundary edge.
- A committed value first appears in the slot-0 output of the next frame.
- pending rises the cycle after wr_en and falls the cycle after the commit edge.
- Reset mid-frame: all outputs return to reset values immediately, without waiting for clk, and any uncommitted write is lost.

## Test plan
Bench parameters: DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
- Reset, then release:
  - During reset: led_en=1111, led_seg=1111111, led_dp=1, frame_done=0.
  - led_en=1110 from cycle 3 to 8, all ones for cycles 9-10, then 1101; frame_done pulses every 32 cycles.
- Write data 0x1234, mask 1111, dp 0000, lzb 0 mid-frame:
  - The display is unchanged and pending=1 until frame_done.
  - Next frame: slot0 seg 1001100, slot1 0000110, slot2 0010010, slot3 1001111.
- Write in the boundary cycle: 0xAAAA pending, then 0xBBBB issued exactly on the boundary edge:
  - The next frame shows A (0001000) and pending stays 1.
  - The frame after shows b (1100000).
- lzb=1, data 0x0050: slots 3 and 2 stay led_en=1111; slot1 shows 0100100; slot0 shows 0000001. Data 0x0000: only slot0 is lit.
- mask 0101, dp 0001, data 0x8888: slots 1 and 3 are never enabled; led_dp=0 only during the slot0 active window.
- Assert rst_n low mid-slot2 with a write pending:
  - Outputs go idle asynchronously.
  - After release, the display shows 0 on all digits and pending=0.
